// File: rtl/counter_161_modn.sv
// ---------------------------------------------------------------------------
// counter_161_modn
//   Parametrised synchronous mod-N counter, successor to the 74LS161 stage.
//   Wrap-around happens inside the block, so there is no external
//   async-clear glitch. Adds up/down counting, synchronous parallel load,
//   a clock-enable prescaler and a registered wrap pulse. Stages cascade
//   through EP/ET/RCO exactly like the '161.
//
// Parameters
//   WIDTH     counter width in bits
//   MODULUS   count range 0..MODULUS-1, legal 2..2**WIDTH
//   PRESCALE  qualifying cycles per count step, legal >= 1
//
// Ports
//   CP    in   clock, rising edge
//   CR_n  in   asynchronous active-low clear
//   LD_n  in   synchronous active-low parallel load (beats counting)
//   EP    in   count enable P
//   ET    in   count enable T, also gates RCO
//   UD    in   direction, 1 = up, 0 = down
//   D     in   parallel load data
//   Q     out  registered count value
//   RCO   out  combinational ripple carry for the next stage's ET
//   WRAP  out  registered one-cycle pulse, one cycle after Q wraps
// ---------------------------------------------------------------------------
module counter_161_modn #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic             CP,
  input  logic             CR_n,
  input  logic             LD_n,
  input  logic             EP,
  input  logic             ET,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             WRAP
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("counter_161_modn: MODULUS must lie in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_161_modn: PRESCALE must be at least 1");
  end

  logic [PRE_W-1:0] pre;
  logic             wrap_hit;
  logic             qual;
  logic             pre_done;
  logic             term;
  logic             above_max;
  logic             wrap_now;
  logic [WIDTH-1:0] q_next;

  assign qual     = EP & ET & LD_n;
  assign pre_done = (pre == PRE_LAST);

  // Terminal count depends on the live direction input, so RCO follows UD
  // immediately without any direction state being stored.
  assign term = UD ? (Q == MAX_Q) : (Q == '0);
  assign RCO  = ET & term & pre_done;

  // An out-of-range Q is treated as terminal: up goes to 0, down goes to
  // MAX_Q. Only genuine wraps from the real terminal value raise wrap_now.
  assign above_max = (Q > MAX_Q);

  always_comb begin
    q_next   = Q;
    wrap_now = 1'b0;
    if (UD) begin
      if (Q >= MAX_Q) begin
        q_next   = '0;
        wrap_now = (Q == MAX_Q);
      end else begin
        q_next = Q + WIDTH'(1);
      end
    end else begin
      if (Q == '0 || above_max) begin
        q_next   = MAX_Q;
        wrap_now = (Q == '0);
      end else begin
        q_next = Q - WIDTH'(1);
      end
    end
  end

  // wrap_hit marks the edge that wrapped Q; WRAP repeats it one edge later
  // so the pulse appears the cycle after Q has wrapped. A load discards
  // any pending pulse.
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      Q        <= '0;
      pre      <= '0;
      wrap_hit <= 1'b0;
      WRAP     <= 1'b0;
    end else if (!LD_n) begin
      Q        <= (D <= MAX_Q) ? D : '0;
      pre      <= '0;
      wrap_hit <= 1'b0;
      WRAP     <= 1'b0;
    end else begin
      WRAP     <= wrap_hit;
      wrap_hit <= 1'b0;
      if (qual) begin
        if (pre_done) begin
          pre      <= '0;
          Q        <= q_next;
          wrap_hit <= wrap_now;
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_161_modn.sv
// ---------------------------------------------------------------------------
// tb_counter_161_modn
//   Self-checking bench for counter_161_modn. Three single stages share one
//   stimulus (mod-10/prescale-1, mod-5/prescale-1, mod-10/prescale-3) and a
//   two-stage mod-10 cascade has its own enables. Expected values come from
//   a vector table, hand-written constants and an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_counter_161_modn;

  localparam int NDUT = 3;

  logic       cp = 1'b0;
  logic       cr_n = 1'b1;
  logic       ld_n = 1'b1;
  logic       ep = 1'b0;
  logic       et = 1'b0;
  logic       ud = 1'b1;
  logic [3:0] d = '0;

  logic [3:0] q_a, q_b, q_c;
  logic       rco_a, rco_b, rco_c;
  logic       wrap_a, wrap_b, wrap_c;

  logic       cas_en = 1'b0;
  logic       cas_ld_n = 1'b1;
  logic       cas_ud = 1'b1;
  logic [3:0] cas_d = '0;
  logic [3:0] q0, q1;
  logic       rco0, rco1, wrap0, wrap1;

  int checks = 0;
  int errors = 0;

  int mq    [NDUT];
  int mpre  [NDUT];
  int mhit  [NDUT];
  int mwrap [NDUT];

  always #5 cp = ~cp;

  counter_161_modn #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .CP(cp), .CR_n(cr_n), .LD_n(ld_n), .EP(ep), .ET(et), .UD(ud), .D(d),
    .Q(q_a), .RCO(rco_a), .WRAP(wrap_a));

  counter_161_modn #(.WIDTH(4), .MODULUS(5), .PRESCALE(1)) dut_b (
    .CP(cp), .CR_n(cr_n), .LD_n(ld_n), .EP(ep), .ET(et), .UD(ud), .D(d),
    .Q(q_b), .RCO(rco_b), .WRAP(wrap_b));

  counter_161_modn #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_c (
    .CP(cp), .CR_n(cr_n), .LD_n(ld_n), .EP(ep), .ET(et), .UD(ud), .D(d),
    .Q(q_c), .RCO(rco_c), .WRAP(wrap_c));

  counter_161_modn #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) stage0 (
    .CP(cp), .CR_n(cr_n), .LD_n(cas_ld_n), .EP(cas_en), .ET(cas_en), .UD(cas_ud),
    .D(cas_d), .Q(q0), .RCO(rco0), .WRAP(wrap0));

  counter_161_modn #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) stage1 (
    .CP(cp), .CR_n(cr_n), .LD_n(cas_ld_n), .EP(cas_en), .ET(rco0), .UD(cas_ud),
    .D(cas_d), .Q(q1), .RCO(rco1), .WRAP(wrap1));

  function automatic int mod_of(input int k);
    return (k == 1) ? 5 : 10;
  endfunction

  function automatic int pre_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic int act_q(input int k);
    case (k)
      0:       return int'(q_a);
      1:       return int'(q_b);
      default: return int'(q_c);
    endcase
  endfunction

  function automatic int act_rco(input int k);
    case (k)
      0:       return int'(rco_a);
      1:       return int'(rco_b);
      default: return int'(rco_c);
    endcase
  endfunction

  function automatic int act_wrap(input int k);
    case (k)
      0:       return int'(wrap_a);
      1:       return int'(wrap_b);
      default: return int'(wrap_c);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      mq[k] = 0; mpre[k] = 0; mhit[k] = 0; mwrap[k] = 0;
    end
  endtask

  // One clock edge of the counting rules, written as modular arithmetic.
  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      int m = mod_of(k);
      if (!ld_n) begin
        mq[k] = (int'(d) < m) ? int'(d) : 0;
        mpre[k] = 0; mhit[k] = 0; mwrap[k] = 0;
      end else begin
        mwrap[k] = mhit[k];
        mhit[k] = 0;
        if (ep && et) begin
          if (mpre[k] == pre_of(k) - 1) begin
            mpre[k] = 0;
            if (ud) begin
              mhit[k] = (mq[k] == m - 1) ? 1 : 0;
              mq[k] = (mq[k] + 1) % m;
            end else begin
              mhit[k] = (mq[k] == 0) ? 1 : 0;
              mq[k] = (mq[k] + m - 1) % m;
            end
          end else begin
            mpre[k] = mpre[k] + 1;
          end
        end
      end
    end
  endtask

  function automatic int model_rco(input int k);
    bit at_term;
    at_term = ud ? (mq[k] == mod_of(k) - 1) : (mq[k] == 0);
    return (et && at_term && mpre[k] == pre_of(k) - 1) ? 1 : 0;
  endfunction

  task automatic check_output(input int k);
    string tag;
    tag = $sformatf("dut%0d", k);
    check({tag, ".q"},    act_q(k),    mq[k]);
    check({tag, ".rco"},  act_rco(k),  model_rco(k));
    check({tag, ".wrap"}, act_wrap(k), mwrap[k]);
  endtask

  task automatic apply_stimulus(input logic l, input logic e, input logic t,
                                input logic u, input logic [3:0] dd);
    ld_n = l; ep = e; et = t; ud = u; d = dd;
  endtask

  task automatic step();
    model_edge();
    @(posedge cp);
    #1;
  endtask

  // Clear with enables off, release mid-cycle, then one idle edge.
  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    cr_n = 1'b0;
    #2;
    cr_n = 1'b1;
    model_reset();
    step();
  endtask

  typedef struct {
    logic       ld_n, ep, et, ud;
    logic [3:0] d;
    int         q;
    logic       rco, wrap;
  } vec_t;

  vec_t vecs [23];
  int   wrap0_count, wrap1_count;

  initial begin
    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, (i + 1) % 10,
                  ((i + 1) % 10 == 9), (i == 10)};
    end
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  7, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  9, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  8, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  8, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  8, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  9, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  9, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1, 1'b0};

    // Asynchronous clear before any clock edge
    #1;
    cr_n = 1'b0;
    #1;
    check("reset.q_a", int'(q_a), 0);
    check("reset.wrap_a", int'(wrap_a), 0);
    check("reset.q_c", int'(q_c), 0);
    check("reset.rco_a", int'(rco_a), 0);
    cr_n = 1'b1;
    model_reset();
    step();

    // Vector table on the mod-10 stage, model on the others
    for (int i = 0; i < 23; i++) begin
      apply_stimulus(vecs[i].ld_n, vecs[i].ep, vecs[i].et, vecs[i].ud, vecs[i].d);
      step();
      check($sformatf("vec%0d.q", i),    int'(q_a),    vecs[i].q);
      check($sformatf("vec%0d.rco", i),  int'(rco_a),  int'(vecs[i].rco));
      check($sformatf("vec%0d.wrap", i), int'(wrap_a), int'(vecs[i].wrap));
      check_output(1);
      check_output(2);
    end

    // Mod-5 down count from zero
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    begin
      int exp_q [6] = '{4, 3, 2, 1, 0, 4};
      for (int i = 0; i < 6; i++) begin
        step();
        check($sformatf("down%0d.q", i),    int'(q_b),    exp_q[i]);
        check($sformatf("down%0d.rco", i),  int'(rco_b),  (exp_q[i] == 0) ? 1 : 0);
        check($sformatf("down%0d.wrap", i), int'(wrap_b), (i == 1) ? 1 : 0);
      end
    end

    // Prescale-3 stage: freeze for two cycles mid-count
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) step();
    check("pre.run", int'(q_c), 1);
    ep = 1'b0;
    step();
    check("pre.hold1", int'(q_c), 1);
    step();
    check("pre.hold2", int'(q_c), 1);
    ep = 1'b1;
    step();
    check("pre.resume1", int'(q_c), 1);
    step();
    check("pre.resume2", int'(q_c), 2);
    check_output(2);

    // Load and clear together: clear wins, also across a clock edge
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    cr_n = 1'b0;
    #1;
    check("ldclr.now", int'(q_a), 0);
    @(posedge cp);
    #1;
    check("ldclr.edge", int'(q_a), 0);
    cr_n = 1'b1;
    model_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step();

    // Mid-cycle clear at Q=6, pre=1 on the prescaled stage
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
    step();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    step();
    check("mid.before_c", int'(q_c), 6);
    check("mid.before_a", int'(q_a), 7);
    #2;
    cr_n = 1'b0;
    #1;
    check("mid.clear_c", int'(q_c), 0);
    check("mid.clear_a", int'(q_a), 0);
    check("mid.clear_wrap", int'(wrap_c), 0);
    cr_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    check("mid.resume_c", int'(q_c), 1);
    check("mid.resume_a", int'(q_a), 3);

    // Two cascaded mod-10 stages count 00..99 and wrap
    do_reset();
    cas_en = 1'b1;
    wrap0_count = 0;
    wrap1_count = 0;
    for (int i = 1; i <= 101; i++) begin
      @(posedge cp);
      #1;
      check($sformatf("cascade%0d", i), int'(q1) * 10 + int'(q0), i % 100);
      if (wrap0) wrap0_count++;
      if (wrap1) wrap1_count++;
    end
    check("cascade.wrap1_pulses", wrap1_count, 1);
    check("cascade.wrap0_pulses", wrap0_count, 10);
    cas_en = 1'b0;

    // Random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)));
      step();
      for (int k = 0; k < NDUT; k++) check_output(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
